// File: rtl/blend_pkg.sv
// blend_pkg: shared state encoding, pixel record and address width for the
// blend scheduler and its scoreboard.
package blend_pkg;

  localparam int PIX_ADDR_W = 19;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    WAIT_ACK = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [PIX_ADDR_W-1:0] addr;
    logic [7:0]            r;
    logic [7:0]            g;
    logic [7:0]            b;
    logic [7:0]            a;
  } pixel_t;

endpackage

// File: rtl/blend_scoreboard.sv
// blend_scoreboard: shift register of {valid, addr} tracking pixels that are
// still inside the blender's read-modify-write pipe. Entry 0 mirrors the
// scheduler output register; an entry falls off the end once the blender
// has written that address back.
module blend_scoreboard
  import blend_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  shift_valid_i,
  input  logic [PIX_ADDR_W-1:0] shift_addr_i,
  input  logic [PIX_ADDR_W-1:0] lookup_addr_i,
  output logic                  hazard_o,
  output logic                  empty_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [PIX_ADDR_W-1:0] addr_q [DEPTH];

  // Advance the in-flight window every cycle; idle cycles insert an empty slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q   <= {valid_q[DEPTH-2:0], shift_valid_i};
      addr_q[0] <= shift_valid_i ? shift_addr_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  // Flag a hazard when the offered address matches any live entry.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr_i)) begin
        hazard_o = 1'b1;
      end else begin
        hazard_o = hazard_o;
      end
    end
  end

  assign empty_o = (valid_q == '0);

endmodule

// File: rtl/blend_scheduler.sv
// blend_scheduler: issues rasterizer pixels to the AlphaBlender one per
// cycle, stalls addresses still in flight (read-after-write hazard), and at
// end of frame drains the blender and performs the frame_ready/ack exchange.
// Optional build macro BLEND_SCHED_ALPHA_SKIP_EN: in-range pixels with
// alpha 8'h00 are consumed without being issued.
module blend_scheduler
  import blend_pkg::*;
#(
  parameter int          BLEND_LATENCY = 2,
  parameter int unsigned NUM_PIXELS    = 307200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIX_ADDR_W-1:0] in_pixel_number,
  input  logic [7:0]            in_r,
  input  logic [7:0]            in_g,
  input  logic [7:0]            in_b,
  input  logic [7:0]            in_a,
  input  logic                  frame_done,
  output logic                  pixel_ready,
  output logic [PIX_ADDR_W-1:0] pixel_number,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic [7:0]            a,
  output logic                  frame_ready,
  input  logic                  blend_frame_ack,
  output logic                  range_err,
  output logic [7:0]            frame_count
);

  sched_state_t state_q, state_d;
  pixel_t       pix_q;
  logic         pixel_ready_q;
  logic         range_err_q;
  logic [7:0]   frame_count_q, frame_count_d;

  logic sb_hazard;
  logic sb_empty;
  logic accept;
  logic in_range;
  logic issue;
  logic drop_range;

  // Pixels whose write has not landed yet; depth covers output reg + blender pipe.
  blend_scoreboard #(
    .DEPTH (BLEND_LATENCY + 1)
  ) u_scoreboard (
    .clk_i         (clk),
    .reset_i       (reset),
    .shift_valid_i (issue),
    .shift_addr_i  (in_pixel_number),
    .lookup_addr_i (in_pixel_number),
    .hazard_o      (sb_hazard),
    .empty_o       (sb_empty)
  );

  assign in_ready   = (state_q == RUN) && !sb_hazard;
  assign accept     = in_valid && in_ready;
  assign in_range   = (32'(in_pixel_number) < NUM_PIXELS);
  assign drop_range = accept && !in_range;

`ifdef BLEND_SCHED_ALPHA_SKIP_EN
  // Fully transparent pixels cannot change the frame buffer, so skip them.
  assign issue = accept && in_range && (in_a != 8'h00);
`else
  assign issue = accept && in_range;
`endif

  // State and frame counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state: run until frame_done, drain the pipe, flush, then wait for ack.
  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    case (state_q)
      RUN: begin
        if (frame_done) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (sb_empty) begin
          state_d = FLUSH;
        end else begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (blend_frame_ack) begin
          state_d       = RUN;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output register: strobes every cycle, data only reloads on an issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q         <= '0;
      pixel_ready_q <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      pixel_ready_q <= issue;
      range_err_q   <= drop_range;
      if (issue) begin
        pix_q <= '{addr: in_pixel_number, r: in_r, g: in_g, b: in_b, a: in_a};
      end
    end
  end

  assign pixel_ready  = pixel_ready_q;
  assign pixel_number = pix_q.addr;
  assign r            = pix_q.r;
  assign g            = pix_q.g;
  assign b            = pix_q.b;
  assign a            = pix_q.a;
  assign range_err    = range_err_q;
  assign frame_ready  = (state_q == FLUSH);
  assign frame_count  = frame_count_q;

endmodule

// File: doc/blend_scheduler.md
# blend_scheduler

Sequences rasterizer pixel traffic into the AlphaBlender read-modify-write datapath. Accepts shaded pixels over a valid/ready handshake and issues them one per cycle. Stalls any pixel whose frame-buffer address is still in flight in the blender, which prevents read-after-write hazards. At end of frame it drains the blender and runs the frame_ready / o_frame_ready exchange.

## Interface
- BLEND_LATENCY, 2, cycles from blender pixel_ready to its write of that pixel; must be ≥1
- NUM_PIXELS, 307200, valid pixel_number range is 0..NUM_PIXELS-1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- in_valid  in  1  rasterizer pixel valid
- in_ready  out  1  scheduler accepts this cycle
- in_pixel_number  in  19  target address
- in_r, in_g, in_b, in_a  in  8 each  source colour and alpha
- frame_done  in  1  one-cycle pulse: last pixel of frame has been offered
- pixel_ready  out  1  issue strobe to blender
- pixel_number  out  19  issued address
- r, g, b, a  out  8 each  issued colour and alpha
- frame_ready  out  1  one-cycle pulse to blender after drain
- blend_frame_ack  in  1  blender o_frame_ready
- range_err  out  1  one-cycle pulse: out-of-range pixel was dropped
- frame_count  out  8  completed frames; wraps 255→0

## Operation
- States: RUN, DRAIN, FLUSH, WAIT_ACK. Reset enters RUN.
- RUN:
  - in_ready = !hazard.
  - hazard = in_pixel_number equals the address of any valid scoreboard entry.
- Scoreboard:
  - Shift register of BLEND_LATENCY+1 {valid, addr} entries; entry 0 mirrors the output register.
  - Shifts every cycle; a zero entry is inserted when nothing issues.
- Accept (in_valid & in_ready), in range:
  - Output register loads the pixel.
  - pixel_ready is high the next cycle.
- Accept, in_pixel_number ≥ NUM_PIXELS:
  - Pixel is consumed, nothing is issued, range_err pulses the next cycle.
  - The address is not entered in the scoreboard.
- frame_done seen in RUN:
  - A pixel accepted in the same cycle is still issued.
  - Next state is DRAIN.
- DRAIN:
  - in_ready = 0.
  - Move to FLUSH when all scoreboard entries are invalid.
- FLUSH:
  - frame_ready = 1 for exactly one cycle.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - in_ready = 0.
  - On blend_frame_ack: frame_count increments, return to RUN.
- frame_done outside RUN is ignored.
- blend_frame_ack outside WAIT_ACK is ignored.
- Output data (pixel_number, r, g, b, a) holds its last value when pixel_ready = 0.

## Timing
- Reset values:
  - All outputs 0, except in_ready = 1 (RUN, empty scoreboard).
  - frame_count = 0.
  - Scoreboard cleared.
- Reset mid-frame: in-flight pixels are forgotten, and no frame_ready is issued for the aborted frame.
- Throughput: one pixel per cycle when addresses do not collide.
- Latency: accept at cycle t → pixel_ready at t+1.
- Hazard release: the same address is accepted again no earlier than t+BLEND_LATENCY+2.
- Drain: the last issue at t gives frame_ready at t+BLEND_LATENCY+3 at the earliest.
- in_ready is combinational from in_pixel_number and the scoreboard. in_ready is also low during DRAIN, FLUSH and WAIT_ACK. The upstream must hold its data while in_valid & !in_ready.

## Configuration
- BLEND_SCHED_ALPHA_SKIP_EN defined: an in-range accepted pixel with in_a == 8'h00 is consumed without issue. No pixel_ready is raised and no scoreboard entry is made.
- Undefined: alpha-zero pixels are issued like any other.

## Structure
- Package blend_pkg holds:
  - typedef sched_state_t {RUN, DRAIN, FLUSH, WAIT_ACK}
  - typedef pixel_t {19-bit addr, 8-bit r, g, b, a}
  - constant PIX_ADDR_W = 19
- Sub-module blend_scoreboard:
  - Parameterised by depth; implements the shift register and the address-match compare.
  - Outputs: hazard, empty.

## Test plan
- Single pixel:
  - Stimulus: pixel 5, rgba 80/40/C0/11 accepted at t.
  - Required: pixel_ready at t+1 with pixel_number=5 and the same rgba.
- Hazard:
  - Stimulus: pixel 7 accepted at t, then pixel 7 offered continuously.
  - Required: in_ready low through t+3; second accept at t+4 with BLEND_LATENCY=2.
- Back-to-back distinct pixels:
  - Stimulus: addresses 0,1,2,3 on consecutive cycles.
  - Required: four consecutive pixel_ready cycles with no stall.
- Range:
  - Stimulus: pixel 307200 offered.
  - Required: accepted, range_err pulses once, no pixel_ready.
- End of frame:
  - Stimulus: last pixel and frame_done in the same cycle t; ack at t+8.
  - Required: pixel issued; frame_ready pulses once at t+5; in_ready low until ack; frame_count goes 0→1; RUN resumes.
- Reset mid-drain:
  - Stimulus: reset asserted in DRAIN.
  - Required: next cycle all outputs are at reset values; no frame_ready follows.
